// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_pkg: definitions shared by the write arbiter and the register bank.
// Contents:
//   DATA_W, ADDR_W, NUM_REGS - write port geometry of the register bank
//   wb_req_t                 - one writeback request (destination + data)
//   out_phase_e              - output phase of the write arbiter
package regfile_pkg;

   localparam int DATA_W   = 26;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 13;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   typedef enum logic {
      PH_IDLE  = 1'b0,
      PH_WRITE = 1'b1
   } out_phase_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback request bus from the NUM_REQ sources.
// Signals:
//   req_valid - per-requester write request
//   req_addr  - per-requester destination register
//   req_data  - per-requester write data
//   req_ready - per-requester holding buffer can accept
// Modports: master = writeback sources, slave = arbiter.
interface regfile_write_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = regfile_pkg::ADDR_W,
   parameter int DATA_W  = regfile_pkg::DATA_W
);

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]             req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick over a request vector.
// Ports:
//   req       in  NUM_REQ  requests (holding buffers that are valid)
//   rr_ptr    in  IDX_W    index where the search starts
//   enable    in  1        0 forces an empty grant
//   grant     out NUM_REQ  one-hot grant, or zero
//   grant_idx out IDX_W    encoded index of the grant (0 when none)
//   grant_any out 1        a grant is issued
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   int idx;

   // Walk the requesters starting at rr_ptr, wrapping around; the first
   // valid one wins, which keeps the grant one-hot.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (enable && !grant_any && req[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register bank write port among NUM_REQ
// writeback sources. Each source owns a one-entry holding buffer; a
// round-robin arbiter drains one buffer per cycle into registered outputs.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   hold      suppress grants this cycle (buffers still fill)
//   wb        request bus (slave side): req_valid/addr/data in, req_ready out
//   we_RF     registered write enable to the register bank
//   A3, WD3   registered write address / data
//   addr_err  one-cycle pulse when a granted entry had an illegal address
//   err_id    requester of the last addr_err, held until the next error
//   busy      any buffer valid or a write in flight
module regfile_write_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hold,
   regfile_write_arbiter_if.slave   wb,
   output logic                     we_RF,
   output logic [ADDR_W-1:0]        A3,
   output logic [DATA_W-1:0]        WD3,
   output logic                     addr_err,
   output logic [IDX_W-1:0]         err_id,
   output logic                     busy
);

   import regfile_pkg::*;

   logic [NUM_REQ-1:0]             buf_valid;
   logic [NUM_REQ-1:0][ADDR_W-1:0] buf_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] buf_data;
   logic [IDX_W-1:0]               rr_ptr;
   logic [NUM_REQ-1:0]             grant;
   logic [IDX_W-1:0]               grant_idx;
   logic                           grant_any;
   logic                           sel_legal;
   out_phase_e                     phase, phase_nxt;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req       (buf_valid),
      .rr_ptr    (rr_ptr),
      .enable    (!hold),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // A buffer being drained this cycle can take a new entry on the same
   // edge. While reset is held every source sees ready, but nothing is
   // captured because the buffer register is in reset.
   assign wb.req_ready = rst ? '1 : (~buf_valid | grant);

   assign sel_legal = 32'(buf_addr[grant_idx]) < 32'(NUM_REGS);

   // Holding buffers: a refill on the drain edge wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (wb.req_valid[i] && wb.req_ready[i]) begin
               buf_valid[i] <= 1'b1;
               buf_addr[i]  <= wb.req_addr[i];
               buf_data[i]  <= wb.req_data[i];
            end else if (grant[i]) begin
               buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   // The search start moves past whoever was just served, error grants
   // included, so an illegal entry cannot stall its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (grant_any) begin
         rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   // Output phase register; we_RF is simply the WRITE phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= PH_IDLE;
      end else begin
         phase <= phase_nxt;
      end
   end

   // Either phase moves to WRITE on a legal grant and to IDLE otherwise;
   // an error grant leaves the write port idle.
   always_comb begin
      phase_nxt = PH_IDLE;
      case (phase)
         PH_IDLE:  if (grant_any && sel_legal) phase_nxt = PH_WRITE;
         PH_WRITE: if (grant_any && sel_legal) phase_nxt = PH_WRITE;
         default:  phase_nxt = PH_IDLE;
      endcase
   end

   // Write address/data only change on a legal grant so the bank sees
   // stable values; the error flag is a one-cycle pulse alongside.
   always_ff @(posedge clk) begin
      if (rst) begin
         A3       <= '0;
         WD3      <= '0;
         addr_err <= 1'b0;
         err_id   <= '0;
      end else begin
         addr_err <= 1'b0;
         if (grant_any) begin
            if (sel_legal) begin
               A3  <= buf_addr[grant_idx];
               WD3 <= buf_data[grant_idx];
            end else begin
               addr_err <= 1'b1;
               err_id   <= grant_idx;
            end
         end
      end
   end

   assign we_RF = (phase == PH_WRITE);
   assign busy  = (|buf_valid) | we_RF;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed scenarios plus a random run, all
// compared cycle by cycle against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;

   localparam int N      = 3;
   localparam int AW     = 5;
   localparam int DW     = 26;
   localparam int NREGS  = 13;
   localparam int IW     = 2;

   logic          clk;
   logic          rst;
   logic          hold;
   logic          we_RF;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD3;
   logic          addr_err;
   logic [IW-1:0] err_id;
   logic          busy;

   regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) wb ();

   regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NREGS)) dut (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .wb       (wb),
      .we_RF    (we_RF),
      .A3       (A3),
      .WD3      (WD3),
      .addr_err (addr_err),
      .err_id   (err_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int compare_count  = 0;
   int mismatch_count = 0;

   // Behavioural model: one pending entry per source, a rotating start
   // point, and the last values presented to the bank.
   bit          m_valid [N];
   int          m_addr  [N];
   logic [DW-1:0] m_data [N];
   int          m_ptr;
   bit          m_we;
   int          m_A3;
   logic [DW-1:0] m_WD3;
   bit          m_err;
   int          m_err_id;
   logic [N-1:0] last_ready;

   logic [N-1:0]         va;
   logic [N-1:0][AW-1:0] aa;
   logic [N-1:0][DW-1:0] da;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs (called just after a falling edge), checks
   // req_ready before the rising edge and the registered outputs after it.
   task applyStimulus(input logic r, input logic h, input logic [N-1:0] v,
                      input logic [N-1:0][AW-1:0] a, input logic [N-1:0][DW-1:0] d);
      int win;
      logic [N-1:0] exp_ready;
      rst = r;
      hold = h;
      wb.req_valid = v;
      wb.req_addr = a;
      wb.req_data = d;
      win = -1;
      if (!h) begin
         for (int k = 0; k < N; k++) begin
            if (win < 0 && m_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         end
      end
      for (int i = 0; i < N; i++) exp_ready[i] = r || !m_valid[i] || (i == win);
      #1;
      last_ready = wb.req_ready;
      checkOutput("req_ready", 32'(wb.req_ready), 32'(exp_ready));
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < N; i++) m_valid[i] = 0;
         m_ptr = 0; m_we = 0; m_A3 = 0; m_WD3 = '0; m_err = 0; m_err_id = 0;
      end else begin
         m_we = 0;
         m_err = 0;
         if (win >= 0) begin
            if (m_addr[win] < NREGS) begin
               m_we = 1; m_A3 = m_addr[win]; m_WD3 = m_data[win];
            end else begin
               m_err = 1; m_err_id = win;
            end
            m_valid[win] = 0;
            m_ptr = (win + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (v[i] && exp_ready[i]) begin
               m_valid[i] = 1; m_addr[i] = int'(a[i]); m_data[i] = d[i];
            end
         end
      end
      @(negedge clk);
      checkOutput("we_RF", 32'(we_RF), 32'(m_we));
      checkOutput("A3", 32'(A3), 32'(m_A3));
      checkOutput("WD3", 32'(WD3), 32'(m_WD3));
      checkOutput("addr_err", 32'(addr_err), 32'(m_err));
      checkOutput("err_id", 32'(err_id), 32'(m_err_id));
      checkOutput("busy", 32'(busy), 32'(m_valid[0] | m_valid[1] | m_valid[2] | m_we));
   endtask

   task idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clk = 0;
      for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_addr[i] = 0; m_data[i] = '0; end
      m_ptr = 0; m_we = 0; m_A3 = 0; m_WD3 = '0; m_err = 0; m_err_id = 0;

      // Reset state
      applyStimulus(1, 0, '0, '0, '0);
      applyStimulus(1, 0, '0, '0, '0);
      checkOutput("rst_ready", 32'(last_ready), 32'h7);
      checkOutput("rst_we", 32'(we_RF), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);

      // Single request: one write, one cycle later
      va = 3'b001; aa = '0; da = '0; aa[0] = 5'd5; da[0] = 26'h12345;
      applyStimulus(0, 0, va, aa, da);
      idleCycles(1);
      checkOutput("single_we", 32'(we_RF), 32'h1);
      checkOutput("single_A3", 32'(A3), 32'd5);
      checkOutput("single_WD3", 32'(WD3), 32'h12345);
      idleCycles(1);
      checkOutput("single_we_end", 32'(we_RF), 32'h0);
      checkOutput("single_busy_end", 32'(busy), 32'h0);

      // Contention: three sources at once, served 1, 2, 3
      applyStimulus(1, 0, '0, '0, '0);
      va = 3'b111;
      for (int i = 0; i < N; i++) begin aa[i] = AW'(i + 1); da[i] = DW'(32'h100 + i); end
      applyStimulus(0, 0, va, aa, da);
      for (int k = 0; k < N; k++) begin
         idleCycles(1);
         checkOutput("contend_we", 32'(we_RF), 32'h1);
         checkOutput("contend_A3", 32'(A3), 32'(k + 1));
      end
      idleCycles(1);
      checkOutput("contend_we_end", 32'(we_RF), 32'h0);

      // Rotation: sources 0 and 2 refilled every cycle alternate
      va = 3'b101; aa = '0; aa[0] = 5'd4; aa[2] = 5'd6;
      for (int n = 1; n <= 10; n++) begin
         da[0] = DW'(n); da[2] = DW'(n + 32'h40);
         applyStimulus(0, 0, va, aa, da);
         if (n >= 2) checkOutput("rotate_A3", 32'(A3), (n % 2 == 0) ? 32'd4 : 32'd6);
      end
      idleCycles(4);

      // Illegal address from source 1, then a legal one at the top register
      va = 3'b010; aa = '0; da = '0; aa[1] = 5'd13; da[1] = 26'h3ABCDEF;
      applyStimulus(0, 0, va, aa, da);
      idleCycles(1);
      checkOutput("illegal_we", 32'(we_RF), 32'h0);
      checkOutput("illegal_err", 32'(addr_err), 32'h1);
      checkOutput("illegal_id", 32'(err_id), 32'h1);
      aa[1] = 5'd12; da[1] = 26'h0055AA;
      applyStimulus(0, 0, va, aa, da);
      checkOutput("illegal_err_end", 32'(addr_err), 32'h0);
      idleCycles(1);
      checkOutput("legal12_we", 32'(we_RF), 32'h1);
      checkOutput("legal12_A3", 32'(A3), 32'd12);
      checkOutput("err_id_held", 32'(err_id), 32'h1);
      idleCycles(2);

      // Hold with all buffers full, then release with a same-cycle refill
      va = 3'b111;
      for (int i = 0; i < N; i++) begin aa[i] = AW'(i + 7); da[i] = DW'(32'h200 + i); end
      applyStimulus(0, 1, va, aa, da);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, '0, '0, '0);
         checkOutput("hold_ready", 32'(last_ready), 32'h0);
         checkOutput("hold_we", 32'(we_RF), 32'h0);
      end
      va = 3'b100; aa[2] = 5'd11; da[2] = 26'h777;
      applyStimulus(0, 0, va, aa, da);
      checkOutput("refill_ready2", 32'(last_ready[2]), 32'h1);
      checkOutput("release_A3", 32'(A3), 32'd9);
      idleCycles(5);

      // Reset in the middle of a burst
      va = 3'b111;
      for (int i = 0; i < N; i++) begin aa[i] = AW'(i + 1); da[i] = DW'(32'h300 + i); end
      applyStimulus(0, 0, va, aa, da);
      idleCycles(1);
      checkOutput("burst_we", 32'(we_RF), 32'h1);
      applyStimulus(1, 0, '0, '0, '0);
      checkOutput("midrst_we", 32'(we_RF), 32'h0);
      checkOutput("midrst_A3", 32'(A3), 32'h0);
      checkOutput("midrst_busy", 32'(busy), 32'h0);
      for (int k = 0; k < 3; k++) begin
         idleCycles(1);
         checkOutput("midrst_lost", 32'(we_RF), 32'h0);
      end

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < N; i++) begin
            va[i] = ($urandom_range(0, 99) < 60);
            aa[i] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(13, 31))
                                                : AW'($urandom_range(0, 13));
            da[i] = DW'($urandom);
         end
         applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10, va, aa, da);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register bank's single write port (we_RF / A3 / WD3) among NUM_REQ writeback sources (ALU, load unit, vector/auxiliary unit). Each source gets a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter drains one buffer per cycle into registered write-port outputs. Out-of-range destinations are dropped and reported. The block sits between the execute/writeback stages and the register bank.

## Interface
Parameters:
- NUM_REQ, 3, number of write requesters (2..4)
- DATA_W, 26, write data width
- ADDR_W, 5, register address width
- NUM_REGS, 13, implemented registers; legal addresses are 0..NUM_REGS-1

Ports:
- clk  in  1  single clock, rising-edge logic
- rst  in  1  reset, synchronous and active-high
- hold  in  1  when 1, no grant is issued this cycle; buffers keep filling
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ×ADDR_W  per-requester destination register
- req_data  in  NUM_REQ×DATA_W  per-requester write data
- req_ready  out  NUM_REQ  per-requester buffer can accept (combinational)
- we_RF  out  1  write enable to register bank, registered
- A3  out  ADDR_W  write address, registered
- WD3  out  DATA_W  write data, registered
- addr_err  out  1  one-cycle pulse: a granted entry had an illegal address
- err_id  out  $clog2(NUM_REQ)  requester index of the last addr_err, held until next error
- busy  out  1  any buffer valid or we_RF high

## Operation
- Per requester i, buf_valid[i], buf_addr[i], buf_data[i].
- req_ready[i] = !buf_valid[i] | grant[i]. A granted buffer may be refilled in the same cycle.
- Accept on a rising edge where req_valid[i] & req_ready[i]: capture addr and data, set buf_valid[i].
- Arbitration is combinational over buf_valid.
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first valid buffer wins: grant[i] is one-hot or zero.
  - grant = 0 when hold = 1.
- On the edge that consumes grant[i]:
  - clear buf_valid[i], unless it is refilled on the same edge.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - If buf_addr[i] < NUM_REGS: we_RF <= 1, A3 <= buf_addr[i], WD3 <= buf_data[i].
  - Otherwise: we_RF <= 0, addr_err <= 1, err_id <= i.
- With no grant: we_RF <= 0, addr_err <= 0. A3 and WD3 hold their last values.
- rr_ptr advances only on a grant, including an error grant.
- Output-phase state machine:
  - IDLE (we_RF=0) -> WRITE on a legal grant.
  - WRITE (we_RF=1) -> WRITE on another legal grant, otherwise IDLE.
  - The error pulse is a separate flag; the state stays or becomes IDLE.

## Timing
- Reset values: buf_valid = 0, rr_ptr = 0, we_RF = 0, A3 = 0, WD3 = 0, addr_err = 0, err_id = 0, busy = 0. req_ready is all ones after reset.
- Latency:
  - Request accepted at edge k, with no contention and hold = 0: we_RF = 1 from edge k+1 to edge k+2.
  - The register bank samples on the falling edge inside that window.
- Throughput: one write per cycle. A requester that is refilled each cycle while uncontested sustains 1 write/cycle.
- Fairness: with all buffers full, NUM_REQ consecutive grants serve every requester exactly once.
- hold asserted: outputs go idle on the next edge. Buffers retain contents, and req_ready[i] = !buf_valid[i].
- Reset asserted mid-operation, at the edge with rst = 1:
  - all buffers are discarded and we_RF = 0;
  - any write not yet registered is lost;
  - req_ready stays high while rst = 1, but no capture happens.
- Address exactly NUM_REGS (13) is illegal. Address NUM_REGS-1 (12) is legal.

## Structure
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, NUM_REGS constants;
  - typedef wb_req_t {addr, data}.
  - The register bank and this block both import it.
- One natural sub-module: rr_arbiter (parameterised NUM_REQ). Inputs are req vector, rr_ptr and enable; outputs are one-hot grant and encoded index.
  - Purely combinational.
  - rr_ptr lives in the parent.

## Test plan
- Single request: rst released, req_valid[0]=1, addr=5, data=26'h12345 for one cycle -> next cycle we_RF=1, A3=5, WD3=26'h12345 for exactly one cycle; busy falls afterwards.
- Contention: all three requesters valid in the same cycle, addrs 1/2/3 -> we_RF high three consecutive cycles with A3 = 1, 2, 3; rr_ptr ends at 0.
- Round-robin rotation: buffers 0 and 2 kept full continuously -> grants alternate 0, 2, 0, 2 and never starve either requester.
- Illegal address: req 1 with addr=13 -> no we_RF, addr_err pulses one cycle, err_id=1. A following legal request from req 1 writes normally.
- Hold and refill: hold=1 for 4 cycles with all buffers full -> we_RF=0, req_ready all low. On release, three writes follow in order from rr_ptr. A same-cycle refill of the granted buffer keeps req_ready[i]=1.
- Reset mid-burst: rst=1 while two buffers are pending and we_RF=1 -> next cycle all outputs are at reset values; the pending entries are never written.
